conv_out_stream: RTL and testbench

CONV_OUT_STREAM -- requirements
Module: conv_out_stream

---
 rtl/conv_out_stream_pkg.sv | 15 +
 rtl/fifo_sync.sv | 38 +++
 rtl/conv_out_stream.sv | 60 ++++++
 tb/tb_conv_out_stream.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/conv_out_stream_pkg.sv
// conv_out_stream_pkg: shared conv-stage constants, pixel tag type and width helper
package conv_out_stream_pkg;
  localparam int CONV_D = 299;
  localparam int CONV_DATA_WIDTH = 32;
  localparam int CONV_FIFO_DEPTH = 16;
  localparam int CONV_PTR_W = $clog2(CONV_FIFO_DEPTH);
  localparam int CONV_CNT_W = CONV_PTR_W + 1;
  typedef struct packed {
    logic eol;
    logic eof;
  } tag_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: first-word fall-through sync fifo; push/pop in, din/dout data, full/empty/count status
module fifo_sync #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + PW'(1);
      if (do_pop) rd <= rd + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/conv_out_stream.sv
// conv_out_stream: tags conv pixels with eol/eof, buffers them (drop+sticky overflow when full) and streams them out valid/ready
module conv_out_stream
  import conv_out_stream_pkg::*;
#(
  parameter int D = CONV_D,
  parameter int data_width = CONV_DATA_WIDTH,
  parameter int FIFO_DEPTH = CONV_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [data_width-1:0]         pxl_in,
  input  logic                          ready_in,
  output logic                          valid_out,
  output logic [data_width-1:0]         pxl_out,
  output logic                          eol_out,
  output logic                          eof_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [15:0]                   frame_cnt
);
  localparam int CW = idx_w(D);
  logic [CW-1:0] col, row;
  logic full, empty, push, pop, eol, eof;
  logic [data_width+1:0] head;
  tag_t head_tag;
  assign eol = col == CW'(D-1);
  assign eof = eol && row == CW'(D-1);
  assign pop = !empty && ready_in;
  assign push = valid_in && (!full || pop);
  fifo_sync #(.WIDTH(data_width + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({pxl_in, tag_t'{eol: eol, eof: eof}}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  assign head_tag = head[1:0];
  assign valid_out = !empty;
  assign pxl_out = valid_out ? head[data_width+1:2] : '0;
  assign eol_out = valid_out && head_tag.eol;
  assign eof_out = valid_out && head_tag.eof;
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      frame_cnt <= '0;
      overflow <= 1'b0;
    end else if (valid_in) begin
      col <= eol ? '0 : col + CW'(1);
      if (eol) row <= eof ? '0 : row + CW'(1);
      if (eof) frame_cnt <= frame_cnt + 16'd1;
      if (!push) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_out_stream.sv
// tb_conv_out_stream: scoreboard bench with frame-index reference model and random stimulus
module tb_conv_out_stream;
  localparam int D = 4;
  localparam int FD = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_in = 1'b0;
  logic ready_in = 1'b0;
  logic [31:0] pxl_in = '0;
  logic valid_out, eol_out, eof_out, overflow;
  logic [31:0] pxl_out;
  logic [4:0] fifo_count;
  logic [15:0] frame_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] exp_q[$];
  int occ = 0;
  int idx = 0;
  logic [15:0] frames = '0;
  logic ovf = 1'b0;
  int peak;

  conv_out_stream #(.D(D), .data_width(32), .FIFO_DEPTH(FD)) dut (
    .clk(clk),
    .reset(reset),
    .valid_in(valid_in),
    .pxl_in(pxl_in),
    .ready_in(ready_in),
    .valid_out(valid_out),
    .pxl_out(pxl_out),
    .eol_out(eol_out),
    .eof_out(eof_out),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: the buffer is just a queue of accepted pixels; a pixel's
  // position in the frame decides its tags.
  always @(posedge clk) begin : model
    bit pop_now, acc;
    if (reset) begin
      occ = 0;
      exp_q.delete();
      idx = 0;
      frames = '0;
      ovf = 1'b0;
    end else begin
      pop_now = occ > 0 && ready_in;
      acc = valid_in && (occ < FD || pop_now);
      if (valid_in) begin
        if (acc) exp_q.push_back({pxl_in, idx % D == D - 1, idx == D * D - 1});
        else ovf = 1'b1;
        if (idx == D * D - 1) frames++;
        idx = (idx + 1) % (D * D);
      end
      occ = occ + int'(acc) - int'(pop_now);
    end
  end

  always @(negedge clk) begin
    chk("valid_out", valid_out, occ != 0);
    chk("fifo_count", fifo_count, occ);
    chk("overflow", overflow, ovf);
    chk("frame_cnt", frame_cnt, frames);
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got pxl %0h, expected none at %0t", pxl_out, $time);
      end else begin
        chk("pixel_tags", {pxl_out, eol_out, eof_out}, exp_q[0]);
        if (ready_in) void'(exp_q.pop_front());
      end
    end else
      chk("idle_zero", {pxl_out, eol_out, eof_out}, 34'd0);
  end

  task automatic step(input logic v, input logic [31:0] p, input logic r);
    valid_in = v;
    pxl_in = p;
    ready_in = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, $urandom, 1'b1);
    step(1'b1, $urandom, 1'b1);
    reset = 1'b0;
  endtask

  task automatic drain();
    repeat (24) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    do_reset();
    chk("reset_count", fifo_count, 0);
    chk("reset_valid", valid_out, 0);
    for (int k = 0; k < 16; k++) step(1'b1, 32'h3f800000 + k, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);
    chk("frame_after_16", frame_cnt, 1);
    for (int k = 0; k < 17; k++) step(1'b1, $urandom, 1'b0);
    chk("full_count", fifo_count, 16);
    chk("overflow_set", overflow, 1);
    drain();
    chk("overflow_sticky", overflow, 1);
    do_reset();
    for (int k = 0; k < 16; k++) step(1'b1, $urandom, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, $urandom, 1'b1);
    chk("full_passthru_count", fifo_count, 16);
    chk("full_passthru_ovf", overflow, 0);
    drain();
    do_reset();
    step(1'b0, '0, 1'b1);
    peak = 0;
    for (int t = 0; t < 16; t++) begin
      step(1'b1, $urandom, 1'(t % 2));
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    chk("toggle_peak", peak, 8);
    drain();
    chk("toggle_no_loss", overflow, 0);
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, $urandom, 1'b1);
    for (int k = 0; k < 2; k++) step(1'b1, $urandom, 1'b0);
    chk("midframe_buffered", fifo_count, 3);
    do_reset();
    chk("midframe_reset_count", fifo_count, 0);
    chk("midframe_reset_frames", frame_cnt, 0);
    for (int k = 0; k < 16; k++) step(1'b1, $urandom, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("frame_after_reset", frame_cnt, 1);
    drain();
    for (int t = 0; t < 600; t++) begin
      if (t == 300) do_reset();
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1) == 1);
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
